mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Multi-cycle multiply/divide sequencer for the pipeline's HI/LO unit.
- Drives one instance of the shared 32-bit alu (ADD/SUB/OR, ALUOp 2-bit) iteratively to implement MULT, MULTU, DIV and DIVU into private HI/LO registers.
- Also services MTHI/MTLO writes.
- Sits beside the EX stage; the hazard unit stalls MFHI/MFLO and new md ops while busy=1.

Parameters:
- HI_INIT, 32'h0000_0000, HI reset value.
- LO_INIT, 32'h0000_0000, LO reset value.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  launch operation; sampled only in IDLE.
- md_op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- A  in  32  rs operand (multiplicand / dividend).
- B  in  32  rt operand (multiplier / divisor).
- hi_we  in  1  MTHI strobe.
- lo_we  in  1  MTLO strobe.
- wdata  in  32  MTHI/MTLO data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse, final busy cycle.
- HI  out  32  HI register.
- LO  out  32  LO register.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, HI=HI_INIT, LO=LO_INIT. Reset mid-operation aborts with no HI/LO commit.
- States and transitions:
  - IDLE -> PREP when start=1; A, B, md_op latched on that edge.
  - PREP (1 cycle): load magnitudes; signed ops take |A|, |B| via local two's-complement negation; record sign flags.
  - ITER (exactly 32 cycles, 5-bit counter 0..31) -> FIX.
  - FIX (2 cycles) -> DONE.
  - DONE (1 cycle) -> IDLE.
- Latency: busy=1 for exactly 36 cycles, starting the cycle after start is sampled. done=1 in the 36th busy cycle only. New HI/LO are visible the cycle after done. Latency is constant for all ops, including unsigned and divide-by-zero.
- Multiply, ITER: accumulator {P_hi, P_lo}, P_lo preloaded with |B|.
  - If P_lo[0]=1, drive the alu with ALUOp=ADD, A=P_hi, B=|A|; carry = (sum < P_hi), unsigned. Otherwise carry=0 and sum=P_hi.
  - Then {P_hi,P_lo} <= {carry,sum,P_lo}>>1.
- Divide, ITER: {R,Q}, Q preloaded with |A|, R=0.
  - Shift {R,Q} left 1; r33 = old R[31].
  - Drive the alu with ALUOp=SUB, A=shifted R, B=|B|.
  - If r33 | (shifted R >= |B|, unsigned local compare): R <= alu C, Q[0] <= 1.
- FIX: the alu computes 0-x (SUB) when the sign flag requires negation.
  - FIX1: low word (product low or quotient).
  - FIX2: high word.
  - Mult: negate 64-bit when sign(A)^sign(B). HI' = ~HI + (LO==0), where the LO==0 test uses the pre-negation low word.
  - Div: quotient negated if sign(A)^sign(B); remainder negated if sign(A).
- Commit in DONE: mult -> HI=P_hi, LO=P_lo; div -> HI=remainder, LO=quotient.
- Divide by zero (B=0): full latency, done pulses, HI/LO unchanged.
- DIV 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0 (falls out of magnitude path).
- start while busy: ignored. hi_we/lo_we while busy: dropped. hi_we/lo_we in IDLE: write takes effect next cycle. start together with hi_we in IDLE: both accepted.
- alu ALUOp when not iterating/fixing: OR with A=B=0 (don't-care, held constant for power).

Decomposition:
- Shared header of `defines`:
  - MD_MULTU/MULT/DIVU/DIV codes.
  - ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_OR=2'b10.
  - State encodings IDLE/PREP/ITER/FIX1/FIX2/DONE.
- One sub-module: a single instance of the team's existing alu module. No other children; magnitude negation and the unsigned compare stay local.

Test Plan:
1. MULTU A=0xFFFF_FFFF, B=0xFFFF_FFFF -> done on busy cycle 36; HI=0xFFFF_FFFE, LO=0x0000_0001.
2. MULT A=0xFFFF_FFFD (-3), B=7 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFEB; MULT 0 x 0x8000_0000 -> HI=LO=0.
3. DIVU 100/7 -> LO=14, HI=2. DIV -7/2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIV 7/-2 -> LO=0xFFFF_FFFD, HI=1.
4. DIV 0x8000_0000/0xFFFF_FFFF -> LO=0x8000_0000, HI=0. DIVU 5/0 with HI=0xAA, LO=0xBB preloaded -> done at 36, HI/LO still 0xAA/0xBB.
5. Second start plus lo_we=1 (wdata=0x1234_5678) on busy cycle 5 -> both ignored, first result committed unchanged. Reset asserted on ITER cycle 10 -> next cycle busy=0, done=0, HI=LO=0, no commit.
6. Idle lo_we=1, wdata=0x1234_5678 -> LO=0x1234_5678 next cycle, HI unchanged. hi_we=1 and start (MULTU 2x3) same cycle -> HI=wdata next cycle, then HI=0, LO=6 after done.

Source files
------------

// File: rtl/mdu_seq_pkg.sv
// Shared types and encodings for the HI/LO multiply/divide sequencer.
package mdu_seq_pkg;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_OR  = 2'b10
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX1 = 3'd3,
    S_FIX2 = 3'd4,
    S_DONE = 3'd5
  } state_e;

  typedef struct packed {
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } md_req_t;

  // Two's-complement magnitude when neg is set.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic neg);
    return neg ? XLEN'(~x + XLEN'(1)) : x;
  endfunction
endpackage

// File: rtl/mdu_seq_alu.sv
// Shared 32-bit ALU: ADD, SUB, OR.
module mdu_seq_alu
  import mdu_seq_pkg::*;
(
  input  alu_op_e         alu_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] c
);
  always_comb begin
    c = a | b;
    case (alu_op)
      ALU_ADD: c = a + b;
      ALU_SUB: c = a - b;
      ALU_OR:  c = a | b;
      default: c = a | b;
    endcase
  end
endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with private HI/LO, using one
// shared ALU iteratively; fixed 36-cycle busy window for every operation.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter logic [31:0] HI_INIT = 32'h0000_0000,
  parameter logic [31:0] LO_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  md_req_t           req_q, req_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   acc_hi_q, acc_hi_d;
  logic [XLEN-1:0]   acc_lo_q, acc_lo_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic              is_div_q, is_div_d;
  logic              div_zero_q, div_zero_d;
  logic              lo_zero_q, lo_zero_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;

  alu_op_e           alu_op;
  logic [XLEN-1:0]   alu_a, alu_b, alu_c;

  logic              req_signed, req_div, neg_lo;
  logic [XLEN-1:0]   mag_a, mag_b, r_sh, q_sh, sum;
  logic              carry;

  assign req_signed = (req_q.op == MD_MULT) || (req_q.op == MD_DIV);
  assign req_div    = (req_q.op == MD_DIVU) || (req_q.op == MD_DIV);
  assign mag_a      = mag(req_q.a, req_signed & req_q.a[XLEN-1]);
  assign mag_b      = mag(req_q.b, req_signed & req_q.b[XLEN-1]);
  assign neg_lo     = sign_a_q ^ sign_b_q;
  assign r_sh       = {acc_hi_q[XLEN-2:0], acc_lo_q[XLEN-1]};
  assign q_sh       = {acc_lo_q[XLEN-2:0], 1'b0};

  mdu_seq_alu u_alu (
    .alu_op (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .c      (alu_c)
  );

  // ALU operand steering; parked at OR 0,0 outside ITER/FIX.
  always_comb begin
    alu_op = ALU_OR;
    alu_a  = '0;
    alu_b  = '0;
    case (state_q)
      S_ITER: begin
        if (is_div_q) begin
          alu_op = ALU_SUB;
          alu_a  = r_sh;
          alu_b  = opnd_q;
        end else if (acc_lo_q[0]) begin
          alu_op = ALU_ADD;
          alu_a  = acc_hi_q;
          alu_b  = opnd_q;
        end
      end
      S_FIX1: begin
        if (neg_lo) begin
          alu_op = ALU_SUB;
          alu_b  = acc_lo_q;
        end
      end
      S_FIX2: begin
        if (!is_div_q && neg_lo) begin
          // ~HI + (pre-negation LO == 0) completes the 64-bit negate
          alu_op = ALU_ADD;
          alu_a  = ~acc_hi_q;
          alu_b  = XLEN'(lo_zero_q);
        end else if (is_div_q && sign_a_q) begin
          alu_op = ALU_SUB;
          alu_b  = acc_hi_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    opnd_d     = opnd_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    is_div_d   = is_div_q;
    div_zero_d = div_zero_q;
    lo_zero_d  = lo_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    sum        = acc_hi_q;
    carry      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d = S_PREP;
          req_d   = '{op: md_op, a: A, b: B};
        end
      end
      S_PREP: begin
        sign_a_d   = req_signed & req_q.a[XLEN-1];
        sign_b_d   = req_signed & req_q.b[XLEN-1];
        is_div_d   = req_div;
        div_zero_d = req_div && (req_q.b == '0);
        cnt_d      = '0;
        acc_hi_d   = '0;
        opnd_d     = req_div ? mag_b : mag_a;
        acc_lo_d   = req_div ? mag_a : mag_b;
        state_d    = S_ITER;
      end
      S_ITER: begin
        if (is_div_q) begin
          // restoring step; the bit shifted out of R forces a subtract
          if (acc_hi_q[XLEN-1] || (r_sh >= opnd_q)) begin
            acc_hi_d = alu_c;
            acc_lo_d = q_sh | XLEN'(1);
          end else begin
            acc_hi_d = r_sh;
            acc_lo_d = q_sh;
          end
        end else begin
          if (acc_lo_q[0]) begin
            sum   = alu_c;
            carry = alu_c < acc_hi_q;
          end
          acc_hi_d = {carry, sum[XLEN-1:1]};
          acc_lo_d = {sum[0], acc_lo_q[XLEN-1:1]};
        end
        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        if (cnt_q == '1) state_d = S_FIX1;
      end
      S_FIX1: begin
        lo_zero_d = (acc_lo_q == '0);
        if (neg_lo) acc_lo_d = alu_c;
        state_d = S_FIX2;
      end
      S_FIX2: begin
        if ((!is_div_q && neg_lo) || (is_div_q && sign_a_q)) acc_hi_d = alu_c;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!div_zero_q) begin
          hi_d = acc_hi_q;
          lo_d = acc_lo_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      opnd_q     <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
      lo_zero_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= HI_INIT;
      lo_q       <= LO_INIT;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      opnd_q     <= opnd_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      is_div_q   <= is_div_d;
      div_zero_q <= div_zero_d;
      lo_zero_q  <= lo_zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;
endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed cases plus random ops against an
// arithmetic reference model.
module tb_mdu_seq;
  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we;
  logic [1:0]  md_op;
  logic [31:0] A, B, wdata;
  logic        busy, done;
  logic [31:0] HI, LO;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] mdl_hi, mdl_lo;

  always #5 clk = ~clk;

  mdu_seq dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  // Reference: {HI, LO} after an op, from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a, b,
                                         input logic [31:0] hi, lo);
    longint sa, sb, q, r;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'b00: return 64'(a) * 64'(b);
      2'b01: return 64'(sa * sb);
      2'b10: begin
        if (b == 32'd0) return {hi, lo};
        return {a % b, a / b};
      end
      default: begin
        if (b == 32'd0) return {hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Start an op from a negedge; returns at the negedge of busy cycle 1.
  task automatic launch(input logic [1:0] op, input logic [31:0] opa, opb);
    start = 1'b1; md_op = op; A = opa; B = opb;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; md_op = 2'($urandom);
  endtask

  // Advance until done is seen; cyc is the busy-cycle index, -1 on timeout.
  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100 || busy !== 1'b1) cyc = -1;
  endtask

  task automatic mt_write(input logic hw, lw, input logic [31:0] d);
    hi_we = hw; lo_we = lw; wdata = d;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0; wdata = $urandom;
    if (hw) mdl_hi = d;
    if (lw) mdl_lo = d;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    md_op = 2'b00; A = '0; B = '0; wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mdl_hi = 32'h0; mdl_lo = 32'h0;
    @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++; $display("FAIL reset_busy_done: got %b expected 00", {busy, done});
    end
    vectors++;
    if (HI !== 32'h0 || LO !== 32'h0) begin
      miscompares++; $display("FAIL reset_hilo: got %h/%h expected 0/0", HI, LO);
    end
  endtask

  task automatic test_mult;
    logic [1:0]  ops [3] = '{2'b00, 2'b01, 2'b01};
    logic [31:0] as  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0};
    logic [31:0] bs  [3] = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000};
    logic [31:0] eh  [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] el  [3] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'h0};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      launch(ops[i], as[i], bs[i]);
      wait_done(1, cyc);
      vectors++;
      if (cyc !== 36) begin
        miscompares++; $display("FAIL mult_latency[%0d]: got %0d expected 36", i, cyc);
      end
      @(negedge clk);
      vectors++;
      if (HI !== eh[i] || LO !== el[i] || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL mult_result[%0d]: got %h/%h busy=%b expected %h/%h busy=0",
                 i, HI, LO, busy, eh[i], el[i]);
      end
      mdl_hi = eh[i]; mdl_lo = el[i];
    end
  endtask

  task automatic test_div;
    logic [1:0]  ops [4] = '{2'b10, 2'b11, 2'b11, 2'b11};
    logic [31:0] as  [4] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] eh  [4] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'h0};
    logic [31:0] el  [4] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      launch(ops[i], as[i], bs[i]);
      wait_done(1, cyc);
      vectors++;
      if (cyc !== 36) begin
        miscompares++; $display("FAIL div_latency[%0d]: got %0d expected 36", i, cyc);
      end
      @(negedge clk);
      vectors++;
      if (HI !== eh[i] || LO !== el[i]) begin
        miscompares++;
        $display("FAIL div_result[%0d]: got %h/%h expected %h/%h", i, HI, LO, eh[i], el[i]);
      end
      mdl_hi = eh[i]; mdl_lo = el[i];
    end
  endtask

  task automatic test_div_zero;
    int cyc;
    mt_write(1'b1, 1'b0, 32'hAA);
    mt_write(1'b0, 1'b1, 32'hBB);
    vectors++;
    if (HI !== 32'hAA || LO !== 32'hBB) begin
      miscompares++; $display("FAIL mt_preload: got %h/%h expected aa/bb", HI, LO);
    end
    launch(2'b10, 32'd5, 32'd0);
    wait_done(1, cyc);
    vectors++;
    if (cyc !== 36) begin
      miscompares++; $display("FAIL divzero_latency: got %0d expected 36", cyc);
    end
    @(negedge clk);
    vectors++;
    if (HI !== 32'hAA || LO !== 32'hBB) begin
      miscompares++; $display("FAIL divzero_hilo: got %h/%h expected aa/bb", HI, LO);
    end
  endtask

  task automatic test_busy_ignore;
    logic [31:0] opa, opb;
    logic [63:0] exp;
    int cyc;
    opa = $urandom; opb = $urandom;
    exp = ref_md(2'b01, opa, opb, mdl_hi, mdl_lo);
    launch(2'b01, opa, opb);
    repeat (4) @(negedge clk);
    start = 1'b1; md_op = 2'b10; A = 32'd9; B = 32'd4;
    lo_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    vectors++;
    if (LO !== mdl_lo) begin
      miscompares++; $display("FAIL busy_lo_we: got %h expected %h", LO, mdl_lo);
    end
    wait_done(6, cyc);
    vectors++;
    if (cyc !== 36) begin
      miscompares++; $display("FAIL busy_latency: got %0d expected 36", cyc);
    end
    @(negedge clk);
    vectors++;
    if ({HI, LO} !== exp) begin
      miscompares++; $display("FAIL busy_result: got %h%h expected %h", HI, LO, exp);
    end
    mdl_hi = exp[63:32]; mdl_lo = exp[31:0];
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL busy_second_start: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    logic saw_done;
    mt_write(1'b1, 1'b1, 32'h5555_AAAA);
    launch(2'b11, $urandom, 32'd3);
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mdl_hi = 32'h0; mdl_lo = 32'h0;
    vectors++;
    if ({busy, done} !== 2'b00 || HI !== 32'h0 || LO !== 32'h0) begin
      miscompares++;
      $display("FAIL midreset_state: got busy=%b done=%b %h/%h expected 0 0 0/0",
               busy, done, HI, LO);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
      miscompares++;
      $display("FAIL midreset_nocommit: got activity=%b %h/%h expected 0 0/0", saw_done, HI, LO);
    end
  endtask

  task automatic test_mt_idle;
    int cyc;
    mt_write(1'b0, 1'b1, 32'h1234_5678);
    vectors++;
    if (LO !== 32'h1234_5678 || HI !== mdl_hi) begin
      miscompares++;
      $display("FAIL mtlo_idle: got %h/%h expected %h/12345678", HI, LO, mdl_hi);
    end
    hi_we = 1'b1; wdata = 32'hCAFE_F00D;
    launch(2'b00, 32'd2, 32'd3);
    hi_we = 1'b0;
    vectors++;
    if (HI !== 32'hCAFE_F00D || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mthi_with_start: got %h busy=%b expected cafef00d busy=1", HI, busy);
    end
    wait_done(1, cyc);
    vectors++;
    if (cyc !== 36) begin
      miscompares++; $display("FAIL mthi_start_latency: got %0d expected 36", cyc);
    end
    @(negedge clk);
    vectors++;
    if (HI !== 32'h0 || LO !== 32'd6) begin
      miscompares++; $display("FAIL mthi_start_result: got %h/%h expected 0/6", HI, LO);
    end
    mdl_hi = 32'h0; mdl_lo = 32'd6;
  endtask

  task automatic test_random;
    logic [1:0]  op;
    logic [31:0] opa, opb;
    logic [63:0] exp;
    int cyc;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) mt_write(1'($urandom), 1'($urandom), $urandom);
      op  = 2'($urandom);
      opa = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       opb = 32'd0;
        1:       opb = 32'hFFFF_FFFF;
        2:       opb = 32'($urandom_range(1, 9));
        default: opb = $urandom;
      endcase
      exp = ref_md(op, opa, opb, mdl_hi, mdl_lo);
      launch(op, opa, opb);
      wait_done(1, cyc);
      vectors++;
      if (cyc !== 36) begin
        miscompares++; $display("FAIL rand_latency[%0d]: got %0d expected 36", i, cyc);
      end
      @(negedge clk);
      vectors++;
      if ({HI, LO} !== exp) begin
        miscompares++;
        $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h%h expected %h",
                 i, op, opa, opb, HI, LO, exp);
      end
      mdl_hi = exp[63:32]; mdl_lo = exp[31:0];
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_busy_ignore();
    test_reset_mid();
    test_mt_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
